hm2reg_arbiter: RTL and testbench
=================================

Name: hm2reg_arbiter

Overview:
- Shares the single HostMot2 register bus (address/data/read/write/chip-select, fixed read latency) between NREQ independent requesters, e.g. the HPS Avalon bridge and on-fabric sequencers.
- Round-robin arbitration; exactly one transaction outstanding at a time.
- Each transaction is accepted, issued as a one-cycle strobe, and acknowledged to its own requester.
- Sits between the requester-side bridges and the hm2 register file.

Parameters:
- NREQ, 2, number of requesters (2..8)
- ADDRESS_WIDTH, 14, hm2 register word address width
- DATA_WIDTH, 32, register data width
- READ_LATENCY, 1, cycles from hm2_read strobe to valid hm2_datain (1..7)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester transaction request; held until accepted
- req_write  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*ADDRESS_WIDTH  packed addresses; slot i at [i*AW +: AW]
- req_wdata  in  NREQ*DATA_WIDTH  packed write data
- req_ready  out  NREQ  one-hot accept pulse
- rsp_valid  out  NREQ  one-hot completion pulse (read data valid / write done)
- rsp_rdata  out  DATA_WIDTH  read data, shared; valid with rsp_valid
- hm2_addr  out  ADDRESS_WIDTH  register address to hm2
- hm2_dataout  out  DATA_WIDTH  write data to hm2
- hm2_datain  in  DATA_WIDTH  read data from hm2
- hm2_read  out  1  read strobe
- hm2_write  out  1  write strobe
- hm2_chipsel  out  1  chip select; high with either strobe
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync deassert via clk): state=IDLE, rr pointer=0, all outputs 0; any in-flight transaction is dropped with no rsp_valid. Strobes fall immediately on reset assertion.
- FSM states:
  - IDLE: if any req_valid, the winner w is the first set bit at or after the pointer, wrapping modulo NREQ. req_ready[w]=1 combinationally in this cycle. On the edge, latch w, write, addr, wdata; pointer <= (w+1) mod NREQ; go to ISSUE. With no request, remain in IDLE.
  - ISSUE (1 cycle): hm2_chipsel=1; hm2_addr=latched addr. Write: hm2_write=1, hm2_dataout=wdata, next state RESP. Read: hm2_read=1, load counter=READ_LATENCY, next state WAIT.
  - WAIT: strobes low; counter decrements each cycle. In the cycle where counter==1, sample hm2_datain into rsp_rdata on that edge, then go to RESP.
  - RESP (1 cycle): rsp_valid[w]=1, then IDLE.
- All hm2_* outputs and rsp_* are registered. req_ready is the only combinational output, and it is low outside IDLE.
- Latency, with acceptance in cycle 0: strobe in cycle 1; write rsp_valid in cycle 2; read rsp_valid in cycle 2+READ_LATENCY.
- Throughput: next acceptance is possible in the cycle after RESP. Writes take 3 cycles per transaction; reads take 3+READ_LATENCY.
- hm2_addr and hm2_dataout hold their last values when idle. rsp_rdata holds until the next read completes; write completions do not change it.
- Simultaneous requests: exactly one accepted per IDLE cycle. With all NREQ continuously requesting, grants rotate 0,1,..,NREQ-1,0.
- A requester that drops req_valid before acceptance is not served. req_valid/addr/data changes after acceptance are ignored.
- Requester w may reassert req_valid in its own RESP cycle; the request is arbitrated in the next IDLE cycle.
- The strobe is never asserted in two consecutive cycles.

Decomposition:
- Shared package hm2reg_pkg: default ADDRESS_WIDTH/DATA_WIDTH constants, FSM state enum (IDLE, ISSUE, WAIT, RESP), max NREQ constant.
- Sub-module rr_pick: NREQ-wide round-robin one-hot picker with registered pointer and advance enable. Reused by later bus sharers.

Test Plan:
- Single write: req 0, addr 0x0123, data 0xDEADBEEF -> req_ready[0] in cycle 0; hm2_write=1 and hm2_chipsel=1 with addr 0x0123 and data 0xDEADBEEF in cycle 1 only; rsp_valid=01 in cycle 2.
- Single read, READ_LATENCY=2: hm2 model returns 0xA5A5_0001 two cycles after the strobe -> rsp_valid[1] in cycle 4; rsp_rdata=0xA5A50001 held afterwards.
- Fairness, NREQ=3: all req_valid held high for 6 transactions -> grant order 0,1,2,0,1,2; each requester gets exactly 2 strobes; no strobe in back-to-back cycles.
- Pointer wrap: after a grant to req 2 (NREQ=3), requests from 0 and 2 -> req 0 wins next.
- Reset mid-read: reset_n low during WAIT -> hm2_read, busy and rsp_valid go to 0 immediately; after release, no stale rsp_valid; the first new request is served from pointer 0.
- Withdrawn request: req 1 asserts, then drops while busy serving req 0 -> req 1 never sees req_ready or a strobe.

Source files
------------

// File: rtl/hm2reg_pkg.sv
// Shared constants and FSM state type for the hm2 register-bus sharers.
package hm2reg_pkg;

    localparam int unsigned DefaultAddrWidth = 14;
    localparam int unsigned DefaultDataWidth = 32;
    localparam int unsigned MaxNreq          = 8;
    localparam int unsigned MaxReadLatency   = 7;
    localparam int unsigned LatCntWidth      = 3;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } hm2reg_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin one-hot picker: first request at or after the pointer, wrapping.
// The pointer moves to just past the winner when advance_i is high.
module rr_pick #(
    parameter int unsigned N = 2,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o
);

    logic [IdxW-1:0]  ptr_q, ptr_d;
    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic             hit;
    int unsigned      off;
    int unsigned      sum;
    int unsigned      nxt;

    always_comb begin
        // rot[i] is the request of slot (ptr + i) mod N
        dbl = {req_i, req_i} >> ptr_q;
        rot = dbl[N-1:0];
        hit = 1'b0;
        off = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (rot[i] && !hit) begin
                hit = 1'b1;
                off = i;
            end
        end
        sum = 32'(ptr_q) + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        nxt = sum + 1;
        if (nxt >= N) begin
            nxt = 0;
        end
        grant_o = '0;
        for (int unsigned k = 0; k < N; k++) begin
            grant_o[k] = hit && (sum == k);
        end
        ptr_d = (advance_i && hit) ? IdxW'(nxt) : ptr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/hm2reg_arbiter.sv
// Round-robin sharer of the single hm2 register bus between NREQ requesters.
// One transaction in flight; all hm2_* and rsp_* outputs come straight from flops.
module hm2reg_arbiter
    import hm2reg_pkg::*;
#(
    parameter int unsigned NREQ          = 2,
    parameter int unsigned ADDRESS_WIDTH = DefaultAddrWidth,
    parameter int unsigned DATA_WIDTH    = DefaultDataWidth,
    parameter int unsigned READ_LATENCY  = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ-1:0]               req_write,
    input  logic [NREQ*ADDRESS_WIDTH-1:0] req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NREQ-1:0]               req_ready,
    output logic [NREQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [ADDRESS_WIDTH-1:0]      hm2_addr,
    output logic [DATA_WIDTH-1:0]         hm2_dataout,
    input  logic [DATA_WIDTH-1:0]         hm2_datain,
    output logic                          hm2_read,
    output logic                          hm2_write,
    output logic                          hm2_chipsel,
    output logic                          busy
);

    if (NREQ < 2 || NREQ > MaxNreq || READ_LATENCY < 1 || READ_LATENCY > MaxReadLatency)
    begin : gen_param_check
        $error("hm2reg_arbiter: parameter out of range");
    end

    hm2reg_state_e            state_q, state_d;
    logic [NREQ-1:0]          grant;
    logic                     accept;
    logic                     sel_write;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_wdata;

    logic [NREQ-1:0]          owner_q, owner_d;
    logic [LatCntWidth-1:0]   cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0] hm2_addr_q, hm2_addr_d;
    logic [DATA_WIDTH-1:0]    hm2_dataout_q, hm2_dataout_d;
    logic                     hm2_read_q, hm2_read_d;
    logic                     hm2_write_q, hm2_write_d;
    logic                     hm2_chipsel_q, hm2_chipsel_d;
    logic [NREQ-1:0]          rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;

    assign accept = (state_q == StIdle) && (|req_valid);

    rr_pick #(
        .N(NREQ)
    ) u_pick (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_i     (req_valid),
        .advance_i (accept),
        .grant_o   (grant)
    );

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                sel_write = req_write[k];
                sel_addr  = req_addr[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                sel_wdata = req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StIssue;
            StIssue: state_d = hm2_write_q ? StResp : StWait;
            StWait:  if (cnt_q == LatCntWidth'(1)) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Strobes and responses are set one edge early so they appear as registered outputs.
    always_comb begin
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        hm2_addr_d    = hm2_addr_q;
        hm2_dataout_d = hm2_dataout_q;
        hm2_read_d    = 1'b0;
        hm2_write_d   = 1'b0;
        hm2_chipsel_d = 1'b0;
        rsp_valid_d   = '0;
        rsp_rdata_d   = rsp_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    owner_d       = grant;
                    hm2_addr_d    = sel_addr;
                    hm2_chipsel_d = 1'b1;
                    if (sel_write) begin
                        hm2_write_d   = 1'b1;
                        hm2_dataout_d = sel_wdata;
                    end else begin
                        hm2_read_d = 1'b1;
                    end
                end
            end
            StIssue: begin
                cnt_d = LatCntWidth'(READ_LATENCY);
                if (hm2_write_q) begin
                    rsp_valid_d = owner_q;
                end
            end
            StWait: begin
                cnt_d = cnt_q - LatCntWidth'(1);
                if (cnt_q == LatCntWidth'(1)) begin
                    rsp_valid_d = owner_q;
                    rsp_rdata_d = hm2_datain;
                end
            end
            StResp: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q       <= '0;
            cnt_q         <= '0;
            hm2_addr_q    <= '0;
            hm2_dataout_q <= '0;
            hm2_read_q    <= 1'b0;
            hm2_write_q   <= 1'b0;
            hm2_chipsel_q <= 1'b0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
        end else begin
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            hm2_addr_q    <= hm2_addr_d;
            hm2_dataout_q <= hm2_dataout_d;
            hm2_read_q    <= hm2_read_d;
            hm2_write_q   <= hm2_write_d;
            hm2_chipsel_q <= hm2_chipsel_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

    assign req_ready   = (state_q == StIdle) ? grant : '0;
    assign busy        = (state_q != StIdle);
    assign hm2_addr    = hm2_addr_q;
    assign hm2_dataout = hm2_dataout_q;
    assign hm2_read    = hm2_read_q;
    assign hm2_write   = hm2_write_q;
    assign hm2_chipsel = hm2_chipsel_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_hm2reg_arbiter.sv
// Bench for hm2reg_arbiter: directed scenarios then random traffic, checked every cycle
// against a transaction-level model (grant rule, fixed latencies, reference register file).
module tb_hm2reg_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned AW   = 14;
    localparam int unsigned DW   = 32;
    localparam int unsigned RL   = 2;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_write = '0;
    logic [NREQ*AW-1:0]   req_addr = '0;
    logic [NREQ*DW-1:0]   req_wdata = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic [AW-1:0]        hm2_addr;
    logic [DW-1:0]        hm2_dataout;
    logic [DW-1:0]        hm2_datain = '0;
    logic                 hm2_read;
    logic                 hm2_write;
    logic                 hm2_chipsel;
    logic                 busy;

    always #5 clk = ~clk;

    hm2reg_arbiter #(
        .NREQ          (NREQ),
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .READ_LATENCY  (RL)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .hm2_addr    (hm2_addr),
        .hm2_dataout (hm2_dataout),
        .hm2_datain  (hm2_datain),
        .hm2_read    (hm2_read),
        .hm2_write   (hm2_write),
        .hm2_chipsel (hm2_chipsel),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [DW-1:0] mem     [1<<AW];
    logic [DW-1:0] ref_mem [1<<AW];

    bit            pend [NREQ];
    bit            pw   [NREQ];
    logic [AW-1:0] pa   [NREQ];
    logic [DW-1:0] pd   [NREQ];
    bit            hold_all = 1'b0;
    bit            rand_en  = 1'b0;

    // transaction-level model: age counts cycles since acceptance
    bit            m_active = 1'b0;
    int            m_age    = 0;
    int            m_w      = 0;
    int            m_ptr    = 0;
    bit            m_write  = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic [DW-1:0] m_wdata  = '0;
    logic [DW-1:0] m_rd     = '0;
    logic [DW-1:0] m_rdata  = '0;

    bit            rd_pend = 1'b0;
    int            rd_due  = 0;
    logic [AW-1:0] rd_addr = '0;
    int            glog[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic post(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[i] = 1'b1;
        pw[i]   = wr;
        pa[i]   = a;
        pd[i]   = d;
    endtask

    function automatic bit any_pend();
        bit r = 1'b0;
        for (int i = 0; i < NREQ; i++) r |= pend[i];
        return r;
    endfunction

    task automatic clear_pend();
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        req_valid = '0;
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cycle();
        logic [NREQ-1:0] exp_rdy;
        int resp_age;
        int w;
        cyc++;
        if (hm2_write) mem[hm2_addr] = hm2_dataout;
        if (hm2_read) begin
            rd_pend = 1'b1;
            rd_due  = cyc + RL;
            rd_addr = hm2_addr;
        end
        if (rd_pend && cyc == rd_due) begin
            hm2_datain = mem[rd_addr];
            rd_pend    = 1'b0;
        end else begin
            hm2_datain = $urandom;
        end

        resp_age = m_write ? 2 : 2 + RL;
        if (m_active && !m_write && m_age == resp_age) m_rdata = m_rd;
        chk("busy", busy, m_active);
        chk("hm2_write", hm2_write, m_active && m_age == 1 && m_write);
        chk("hm2_read", hm2_read, m_active && m_age == 1 && !m_write);
        chk("hm2_chipsel", hm2_chipsel, m_active && m_age == 1);
        chk("hm2_addr", hm2_addr, m_addr);
        if (m_active && m_age == 1 && m_write) chk("hm2_dataout", hm2_dataout, m_wdata);
        chk("rsp_valid", rsp_valid, (m_active && m_age == resp_age) ? (1 << m_w) : 0);
        chk("rsp_rdata", rsp_rdata, m_rdata);

        for (int i = 0; i < NREQ; i++) begin
            if ((hold_all || (rand_en && $urandom_range(3) == 0)) && !pend[i]) begin
                post(i, 1'($urandom_range(1)), AW'($urandom_range(15)), $urandom);
            end else if (rand_en && pend[i] && $urandom_range(31) == 0) begin
                pend[i] = 1'b0;
            end
            req_valid[i]          = pend[i];
            req_write[i]          = pw[i];
            req_addr[i*AW +: AW]  = pa[i];
            req_wdata[i*DW +: DW] = pd[i];
        end
        #1;
        exp_rdy = '0;
        w = -1;
        if (!m_active) begin
            for (int k = 0; k < NREQ; k++) begin
                int j = (m_ptr + k) % NREQ;
                if (w < 0 && pend[j]) w = j;
            end
        end
        if (w >= 0) exp_rdy[w] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) glog.push_back(k);

        if (w >= 0) begin
            m_active = 1'b1;
            m_age    = 1;
            m_w      = w;
            m_write  = pw[w];
            m_addr   = pa[w];
            if (pw[w]) begin
                m_wdata       = pd[w];
                ref_mem[pa[w]] = pd[w];
            end else begin
                m_rd = ref_mem[pa[w]];
            end
            m_ptr   = (w + 1) % NREQ;
            pend[w] = 1'b0;
        end else if (m_active) begin
            if (m_age == resp_age) m_active = 1'b0;
            else m_age++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_idle(input string tag);
        int budget = 100;
        do begin
            cycle();
            budget--;
        end while ((m_active || any_pend()) && budget > 0);
        chk(tag, m_active || any_pend(), 0);
    endtask

    task automatic do_reset();
        clear_pend();
        reset_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_read", hm2_read, 0);
        chk("rst_write", hm2_write, 0);
        chk("rst_chipsel", hm2_chipsel, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_addr", hm2_addr, 0);
        chk("rst_dataout", hm2_dataout, 0);
        chk("rst_rdata", rsp_rdata, 0);
        m_active = 1'b0;
        m_age    = 0;
        m_write  = 1'b0;
        m_ptr    = 0;
        m_addr   = '0;
        m_rdata  = '0;
        rd_pend  = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int budget;
        int n1;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < NREQ; i++) post(i, 1'b0, '0, '0);
        #2;
        do_reset();

        // single write
        post(0, 1'b1, 14'h0123, 32'hDEADBEEF);
        run_idle("wr0_done");

        // single read, data held afterwards
        mem[14'h0456]     = 32'hA5A50001;
        ref_mem[14'h0456] = 32'hA5A50001;
        post(1, 1'b0, 14'h0456, '0);
        run_idle("rd1_done");
        repeat (3) cycle();
        chk("rdata_held", rsp_rdata, 32'hA5A50001);

        // fairness with all requesters held high
        do_reset();
        glog.delete();
        hold_all = 1'b1;
        budget = 200;
        while (glog.size() < 6 && budget > 0) begin
            cycle();
            budget--;
        end
        hold_all = 1'b0;
        clear_pend();
        run_idle("fair_done");
        chk("fair_count", glog.size(), 6);
        for (int k = 0; k < 6 && k < glog.size(); k++) chk("fair_order", glog[k], k % NREQ);

        // pointer wrap after a grant to requester 2
        glog.delete();
        post(0, 1'b1, 14'h0010, 32'h0000_1111);
        post(2, 1'b1, 14'h0011, 32'h0000_2222);
        run_idle("wrap_done");
        chk("wrap_count", glog.size(), 2);
        if (glog.size() >= 2) begin
            chk("wrap_first", glog[0], 0);
            chk("wrap_second", glog[1], 2);
        end

        // reset during WAIT of a read from requester 0
        post(0, 1'b0, 14'h0011, '0);
        budget = 20;
        while (!(m_active && m_age == 2) && budget > 0) begin
            cycle();
            budget--;
        end
        chk("reach_wait_busy", busy, 1);
        do_reset();
        repeat (4) cycle();
        glog.delete();
        post(0, 1'b1, 14'h0020, 32'h0BAD_F00D);
        post(1, 1'b1, 14'h0021, 32'h600D_CAFE);
        run_idle("postrst_done");
        if (glog.size() >= 1) chk("postrst_first", glog[0], 0);
        else chk("postrst_count", glog.size(), 2);

        // withdrawn request is never served
        post(2, 1'b1, 14'h0030, 32'h3333_3333);
        cycle();
        glog.delete();
        post(1, 1'b1, 14'h0031, 32'h1111_0000);
        cycle();
        pend[1] = 1'b0;
        run_idle("wd_done");
        n1 = 0;
        foreach (glog[k]) if (glog[k] == 1) n1++;
        chk("wd_no_grant", n1, 0);

        // random traffic
        rand_en = 1'b1;
        repeat (400) cycle();
        rand_en = 1'b0;
        clear_pend();
        run_idle("rand_done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
